mem_access: RTL and testbench

Memory-access stage of the five-stage pipeline, between execute and write-back. It issues load/store requests to the data memory over a ready-based handshake and stalls the upstream stages while a request is outstanding. It captures the load data, ALU result and destination register into the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_access_wb_reg.sv | 36 +++
 rtl/mem_access.sv | 153 +++++++++++++++
 tb/tb_mem_access.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// =============================================================================
// mem_access_pkg : shared types and defaults for the memory-access stage
// Revision 1.0
// =============================================================================
`default_nettype none

package mem_access_pkg;

   localparam int MEM_TIMEOUT_DEFAULT = 16;
   localparam int MEM_ADDR_W          = 5;
   localparam int MEM_DATA_W          = 32;

   typedef enum logic [0:0] {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic                  valid;
      logic                  mem_to_reg;
      logic                  reg_write;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] read_data;
      logic [31:0]           alu_out;
   } mem_wb_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_wb_reg.sv
// =============================================================================
// mem_wb_reg : MEM/WB pipeline register with load-enable and bubble insertion
// Revision 1.0
// =============================================================================
`default_nettype none

module mem_wb_reg
   import mem_access_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    i_load,
   input  logic    i_bubble,
   input  mem_wb_t i_d,
   output mem_wb_t o_q
);

   mem_wb_t r_q;

   // A bubble kills the slot but leaves the data fields holding their last values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end else if (i_bubble) begin
         r_q.valid     <= 1'b0;
         r_q.reg_write <= 1'b0;
      end
   end

   assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// =============================================================================
// mem_access : pipeline memory stage; ready-handshake to data memory, stalls
//              upstream while waiting. Optional abort: MEM_ACCESS_TIMEOUT_EN.
// Revision 1.0
// =============================================================================
`default_nettype none

module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_LINE      = MEM_ADDR_W,
   parameter int D_SIZE         = MEM_DATA_W,
   parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_valid,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 mem_to_reg_in,
   input  logic                 reg_write_in,
   input  logic [31:0]          alu_out_in,
   input  logic [D_SIZE-1:0]    store_data,
   input  logic [ADDR_LINE-1:0] rd_addr_in,
   output logic                 stall,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [31:0]          dmem_addr,
   output logic [D_SIZE-1:0]    dmem_wdata,
   input  logic                 dmem_ready,
   input  logic [D_SIZE-1:0]    dmem_rdata,
`ifdef MEM_ACCESS_TIMEOUT_EN
   output logic                 mem_timeout_err,
`endif
   output logic                 wb_valid,
   output logic                 wb_mem_to_reg,
   output logic                 wb_reg_write,
   output logic [ADDR_LINE-1:0] wb_addr_in,
   output logic [D_SIZE-1:0]    wb_read_data,
   output logic [31:0]          wb_alu_out
);

   mem_state_t r_state;
   mem_state_t w_next;
   logic       w_acc;
   logic       w_is_load;
   logic       w_req;
   logic       w_stall;
   logic       w_timeout;
   mem_wb_t    w_wb_d;
   mem_wb_t    w_wb_q;

   assign w_acc     = ex_valid & (mem_read | mem_write);
   assign w_is_load = mem_read & ~mem_write;

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_timeout_err;

   assign w_timeout = (r_state == MEM_WAIT) & ~dmem_ready
                    & (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout;
         if (r_state == MEM_IDLE) begin
            r_wait_cnt <= '0;
         end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

   assign mem_timeout_err = r_timeout_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = |TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= MEM_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_req   = 1'b0;
      w_stall = 1'b0;
      case (r_state)
         MEM_IDLE: begin
            w_req   = w_acc;
            w_stall = w_acc & ~dmem_ready;
            if (w_stall) begin
               w_next = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            w_req   = ~w_timeout;
            w_stall = ~dmem_ready & ~w_timeout;
            if (dmem_ready | w_timeout) begin
               w_next = MEM_IDLE;
            end
         end
         default: w_next = MEM_IDLE;
      endcase
   end

   // Reset is asynchronous, so the request must vanish without waiting for an edge
   assign dmem_req   = w_req & ~rst;
   assign stall      = w_stall & ~rst;
   assign dmem_we    = mem_write & ~rst;
   assign dmem_addr  = rst ? '0 : alu_out_in;
   assign dmem_wdata = rst ? '0 : store_data;

   always_comb begin
      w_wb_d            = '0;
      w_wb_d.valid      = ex_valid;
      w_wb_d.mem_to_reg = mem_to_reg_in;
      w_wb_d.reg_write  = reg_write_in & ex_valid & ~w_timeout;
      w_wb_d.addr       = rd_addr_in;
      w_wb_d.read_data  = (ex_valid & w_is_load & ~w_timeout) ? dmem_rdata : '0;
      w_wb_d.alu_out    = alu_out_in;
   end

   mem_wb_reg u_mem_wb_reg (
      .clk      (clk),
      .rst      (rst),
      .i_load   (~w_stall),
      .i_bubble (w_stall),
      .i_d      (w_wb_d),
      .o_q      (w_wb_q)
   );

   assign wb_valid      = w_wb_q.valid;
   assign wb_mem_to_reg = w_wb_q.mem_to_reg;
   assign wb_reg_write  = w_wb_q.reg_write;
   assign wb_addr_in    = w_wb_q.addr;
   assign wb_read_data  = w_wb_q.read_data;
   assign wb_alu_out    = w_wb_q.alu_out;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// =============================================================================
// tb_mem_access : directed plus randomized checks of mem_access
// Revision 1.0
// =============================================================================
`default_nettype none

module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic        mem_to_reg_in = 1'b0, reg_write_in = 1'b0;
   logic [31:0] alu_out_in = '0, store_data = '0;
   logic [4:0]  rd_addr_in = '0;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ready = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        wb_valid, wb_mem_to_reg, wb_reg_write;
   logic [4:0]  wb_addr_in;
   logic [31:0] wb_read_data, wb_alu_out;
`ifdef MEM_ACCESS_TIMEOUT_EN
   logic        mem_timeout_err;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_access #(.ADDR_LINE(5), .D_SIZE(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
      .alu_out_in(alu_out_in), .store_data(store_data), .rd_addr_in(rd_addr_in),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
`ifdef MEM_ACCESS_TIMEOUT_EN
      .mem_timeout_err(mem_timeout_err),
`endif
      .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
      .wb_addr_in(wb_addr_in), .wb_read_data(wb_read_data), .wb_alu_out(wb_alu_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One instruction from EX/MEM entry to MEM/WB retire; memory answers after
   // 'waits' stalled cycles. Expected values come straight from the stage rules.
   task automatic run_instr(input logic v, input logic rd, input logic wr,
                            input logic m2r, input logic rw,
                            input logic [31:0] alu, input logic [31:0] sd,
                            input logic [4:0] rdst, input logic [31:0] rdata,
                            input int waits);
      logic acc;
      int   k;
      acc = v & (rd | wr);
      k   = acc ? waits : 0;
      ex_valid = v; mem_read = rd; mem_write = wr;
      mem_to_reg_in = m2r; reg_write_in = rw;
      alu_out_in = alu; store_data = sd; rd_addr_in = rdst;
      for (int c = 0; c <= k; c++) begin
         dmem_ready = acc ? (c == k) : 1'($urandom);
         dmem_rdata = (c == k) ? rdata : $urandom;
         #3;
         chk("stall", stall, acc && (c < k));
         chk("dmem_req", dmem_req, acc);
         if (acc) begin
            chk("dmem_we", dmem_we, wr);
            chk("dmem_addr", dmem_addr, alu);
            if (wr) chk("dmem_wdata", dmem_wdata, sd);
         end
         @(posedge clk); #1;
         if (c < k) begin
            chk("bubble_valid", wb_valid, 1'b0);
            chk("bubble_reg_write", wb_reg_write, 1'b0);
         end
      end
      chk("wb_valid", wb_valid, v);
      chk("wb_reg_write", wb_reg_write, rw & v);
      chk("wb_mem_to_reg", wb_mem_to_reg, m2r);
      chk("wb_addr_in", wb_addr_in, rdst);
      chk("wb_alu_out", wb_alu_out, alu);
      chk("wb_read_data", wb_read_data, (v & rd & ~wr) ? rdata : 32'h0);
   endtask

   initial begin
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_dmem_req", dmem_req, 1'b0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_read_data", wb_read_data, 32'h0);
      chk("rst_wb_alu_out", wb_alu_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_instr(1, 0, 0, 0, 1, 32'h1234, 32'h0, 5'd7, 32'h0, 0);
      run_instr(1, 1, 0, 1, 1, 32'h40, 32'h0, 5'd3, 32'hDEADBEEF, 0);
      run_instr(1, 0, 1, 0, 0, 32'h80, 32'hA5A5A5A5, 5'd0, 32'h0, 3);
      run_instr(1, 1, 0, 1, 1, 32'h0, 32'h0, 5'd1, 32'h11112222, 0);
      run_instr(1, 1, 0, 1, 1, 32'h4, 32'h0, 5'd2, 32'h33334444, 0);
      run_instr(1, 1, 1, 0, 1, 32'hC, 32'h77, 5'd9, 32'hFFFF0000, 1);
      run_instr(0, 1, 0, 1, 1, 32'h10, 32'h0, 5'd4, 32'h55, 2);

      // Reset in the second WAIT cycle of a load
      ex_valid = 1; mem_read = 1; mem_write = 0; mem_to_reg_in = 1; reg_write_in = 1;
      alu_out_in = 32'h200; rd_addr_in = 5'd6; dmem_ready = 0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("arst_dmem_req", dmem_req, 1'b0);
      chk("arst_stall", stall, 1'b0);
      chk("arst_wb_valid", wb_valid, 1'b0);
      chk("arst_wb_alu_out", wb_alu_out, 32'h0);
      chk("arst_wb_read_data", wb_read_data, 32'h0);
      chk("arst_wb_addr_in", wb_addr_in, 5'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(1, 1, 0, 1, 1, 32'h300, 32'h0, 5'd8, 32'hCAFEF00D, 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
      ex_valid = 1; mem_read = 1; mem_write = 0; mem_to_reg_in = 1; reg_write_in = 1;
      alu_out_in = 32'h400; rd_addr_in = 5'd5; dmem_ready = 0;
      for (int c = 0; c <= 4; c++) begin
         #3;
         chk("to_stall", stall, c < 4);
         chk("to_dmem_req", dmem_req, c < 4);
         @(posedge clk); #1;
      end
      chk("to_err", mem_timeout_err, 1'b1);
      chk("to_wb_valid", wb_valid, 1'b1);
      chk("to_wb_reg_write", wb_reg_write, 1'b0);
      chk("to_wb_read_data", wb_read_data, 32'h0);
      ex_valid = 0;
      @(posedge clk); #1;
      chk("to_err_clear", mem_timeout_err, 1'b0);
`endif

      for (int i = 0; i < 60; i++) begin
         run_instr(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), $urandom, $urandom,
                   5'($urandom), $urandom, int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
